// File: rtl/hebb_trainer_if.sv
// Control and weight-memory bus between the Hebbian trainer and its controller/RAM.
// The slave side is the trainer; the master side drives requests and returns read data.
interface hebb_trainer_if #(parameter int N = 25);
  logic              start;
  logic              clear;
  logic [N-1:0]      pattern;
  logic              busy;
  logic              done;
  logic [3:0]        pat_count;
  logic [9:0]        w_addr;
  logic              w_we;
  logic signed [7:0] w_wdata;
  logic signed [7:0] w_rdata;

  modport master (
    output start, clear, pattern, w_rdata,
    input  busy, done, pat_count, w_addr, w_we, w_wdata
  );

  modport slave (
    input  start, clear, pattern, w_rdata,
    output busy, done, pat_count, w_addr, w_we, w_wdata
  );
endinterface

// File: rtl/hebb_trainer.sv
// Hebbian trainer: read-modify-writes the N*N signed weight memory with the bipolar
// outer product of each accepted pattern, and provides a bulk clear of that memory.
module hebb_trainer #(
  parameter int N      = 25,
  parameter int WMAX   = 127,
  parameter int MAXPAT = 15
) (
  input  logic         clk,
  input  logic         rst,
  hebb_trainer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLR, RD, WR} state_t;

  localparam logic [9:0]        LAST_ADDR = 10'(N * N - 1);
  localparam logic [4:0]        LAST_IDX  = 5'(N - 1);
  localparam logic [3:0]        CNT_MAX   = 4'(MAXPAT);
  localparam logic signed [8:0] POS_LIM   = 9'(WMAX);
  localparam logic signed [8:0] NEG_LIM   = -POS_LIM;

  state_t            state, state_n;
  logic [4:0]        i, j, i_n, j_n;
  logic [9:0]        idx, idx_n;
  logic [N-1:0]      pat_q, pat_q_n;
  logic [3:0]        cnt, cnt_n;
  logic              done_q, done_n;
  logic [9:0]        addr_ij;
  logic signed [8:0] sum;
  logic signed [7:0] upd;

  // Row stride is N, so the memory stays densely packed at 625 entries.
  always_comb begin
    addr_ij = 10'(i) * 10'(N) + 10'(j);
    sum     = $signed({bus.w_rdata[7], bus.w_rdata}) +
              ((pat_q[i] == pat_q[j]) ? 9'sd1 : -9'sd1);
    if (sum > POS_LIM)
      upd = POS_LIM[7:0];
    else if (sum < NEG_LIM)
      upd = NEG_LIM[7:0];
    else
      upd = sum[7:0];
  end

  always_comb begin
    state_n     = state;
    i_n         = i;
    j_n         = j;
    idx_n       = idx;
    pat_q_n     = pat_q;
    cnt_n       = cnt;
    done_n      = 1'b0;
    bus.w_we    = 1'b0;
    bus.w_addr  = '0;
    bus.w_wdata = '0;
    case (state)
      IDLE: begin
        if (bus.clear) begin
          idx_n   = '0;
          state_n = CLR;
        end else if (bus.start) begin
          pat_q_n = bus.pattern;
          i_n     = '0;
          j_n     = '0;
          state_n = RD;
        end
      end
      CLR: begin
        bus.w_we   = 1'b1;
        bus.w_addr = idx;
        idx_n      = idx + 10'd1;
        if (idx == LAST_ADDR) begin
          state_n = IDLE;
          done_n  = 1'b1;
          cnt_n   = '0;
        end
      end
      RD: begin
        bus.w_addr = addr_ij;
        state_n    = WR;
      end
      WR: begin
        bus.w_addr  = addr_ij;
        bus.w_we    = 1'b1;
        bus.w_wdata = (i == j) ? 8'sd0 : upd;
        state_n     = RD;
        if (j == LAST_IDX) begin
          j_n = '0;
          if (i == LAST_IDX) begin
            state_n = IDLE;
            done_n  = 1'b1;
            cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + 4'd1;
          end else begin
            i_n = i + 5'd1;
          end
        end else begin
          j_n = j + 5'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      idx    <= '0;
      pat_q  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      i      <= i_n;
      j      <= j_n;
      idx    <= idx_n;
      pat_q  <= pat_q_n;
      cnt    <= cnt_n;
      done_q <= done_n;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.pat_count = cnt;

endmodule

// File: doc/hebb_trainer.md
Name: hebb_trainer

Overview:
Hebbian learning engine for the 25-neuron (5x5) associative-recall array. It writes the 625-entry signed 8-bit weight memory that the recall engine reads, replacing fixed compiled-in weights with weights learned at run time. For each accepted 25-bit pattern it read-modify-writes every weight w[i][j] by the bipolar outer product. It also provides a bulk clear operation.

Parameters:
N, 25, neuron count; the weight memory depth is N*N.
WMAX, 127, positive saturation limit; the negative limit is -WMAX.
MAXPAT, 15, saturation value of pat_count.

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-low
start  input  1  train-request pulse; sampled only in IDLE
clear  input  1  clear-request pulse; sampled only in IDLE
pattern  input  25  pattern to learn; bit k = neuron k, 1 = +1, 0 = -1
busy  output  1  high while not in IDLE
done  output  1  one-cycle pulse when an operation completes
pat_count  output  4  patterns learned since the last clear, saturating at MAXPAT
w_addr  output  10  weight memory address = i*N + j
w_we  output  1  weight write enable
w_wdata  output  8  signed write data
w_rdata  input  8  signed read data, valid one cycle after w_addr is presented

Behaviour:
- Reset (rst=0 at posedge clk):
  - State goes to IDLE.
  - busy=0, done=0, w_we=0, w_addr=0, w_wdata=0, pat_count=0.
  - Weight memory is not touched.
  - Reset mid-operation aborts immediately; a partially updated memory is acceptable.
- States: IDLE, CLR, RD, WR.
- IDLE:
  - If clear=1, go to CLR with the index at 0. Clear wins if clear and start are both high.
  - Else if start=1, latch pattern into pat_q, set i=j=0, go to RD.
  - start and clear are ignored outside IDLE and are not queued.
- CLR:
  - Each cycle: w_we=1, w_wdata=0, w_addr=index, then index increments.
  - After address 624 is written: go to IDLE, pulse done, set pat_count=0.
  - Duration is 625 cycles.
- RD:
  - w_addr=i*N+j, w_we=0. Next state is WR.
- WR:
  - w_addr is held from RD; w_we=1.
  - If i==j, w_wdata=0 (the diagonal is always forced to zero).
  - Otherwise w_wdata = sat(w_rdata + p), where p=+1 if pat_q[i]==pat_q[j], else -1.
  - The addition is 9-bit signed; sat clamps to the range [-WMAX, +WMAX].
  - Index advance: j++. When j==N-1, wrap j to 0 and increment i.
  - After i=N-1, j=N-1: go to IDLE, pulse done, pat_count++ (saturating).
  - Otherwise return to RD.
- Training takes 2*625 = 1250 cycles from the first RD to the last WR. done is asserted the cycle after the last WR; busy falls on that same cycle.
- w_addr is computed combinationally or registered, but it must equal i*N+j during both RD and WR. The stride for i is N, not 32.
- The symmetry w[i][j]==w[j][i] is preserved automatically because the update is symmetric.
- The pattern input may change while busy; only pat_q is used.

Test Plan:
- Assert rst=0 for 2 cycles with start=1 -> busy=0, done=0, pat_count=0, and no w_we pulses.
- Pulse clear -> exactly 625 consecutive writes of 0 covering addresses 0..624, then a single done pulse and pat_count=0.
- Clear, then train pattern 25'h1FFFFFF -> every off-diagonal weight = +1, all 25 diagonal weights = 0, pat_count=1, done exactly 1250 cycles after busy rises.
- Clear, then train the recall-demo pattern 25'b0111010011100100001001110 -> w[0][1] = -1 (bits differ), w[1][2] = +1, w[12][12] = 0; the memory is symmetric.
- Preload w[0][1]=127 and w[0][2]=-127 with pattern bits 0 and 1 equal and bits 0 and 2 different -> after training, w[0][1] stays 127 and w[0][2] stays -127.
- Drive start and clear together in IDLE -> a CLR operation runs; assert start mid-training -> it is ignored; drop rst mid-RD -> next cycle busy=0 and w_we=0.
